// File: rtl/cmp_pkg.sv
// Shared result codes and controller states for the sequential magnitude comparator.
package cmp_pkg;

  localparam logic [2:0] CMP_NONE = 3'b000;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_GT   = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_compare.sv
// Unsigned equality / less-than of two CHUNK-bit slices.
// Purely combinational, so it adds no latency and applies no backpressure.
module chunk_compare #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] z,
  output logic             eq,
  output logic             lt
);

  assign eq = (x == z);
  assign lt = (x < z);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// MSB-first chunked magnitude compare with early exit; 1..NCHUNK cycles per result.
// Holds y/out_valid indefinitely under out_ready=0; in_ready only in IDLE.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_magnitude_comparator: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [2:0]        y_q, y_d;

  logic [CHUNK-1:0]  a_chunk, b_chunk;
  logic              ch_eq, ch_lt;

  assign a_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(idx_q)*CHUNK +: CHUNK];

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .x  (a_chunk),
    .z  (b_chunk),
    .eq (ch_eq),
    .lt (ch_lt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = a;
          b_d = b;
          // Offset-binary: flipping both sign bits lets the unsigned chunk compare order signed values.
          if (signed_mode) begin
            a_d[WIDTH-1] = ~a[WIDTH-1];
            b_d[WIDTH-1] = ~b[WIDTH-1];
          end
          idx_d   = IDXW'(NCHUNK - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (!ch_eq) begin
          y_d     = ch_lt ? CMP_LT : CMP_GT;
          state_d = DONE;
        end else if (idx_q == '0) begin
          y_d     = CMP_EQ;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      y_q     <= CMP_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomized and directed checks of seq_magnitude_comparator against an arithmetic reference model.
module tb_seq_magnitude_comparator;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       y;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int n_checks;
  int n_fail;
  logic [2:0] prev_y;

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .y           (y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference relation from plain integer arithmetic.
  function automatic logic [2:0] ref_rel(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                         input logic sm);
    int va, vb;
    if (sm) begin
      va = int'($signed(ra));
      vb = int'($signed(rb));
    end else begin
      va = int'(ra);
      vb = int'(rb);
    end
    if (va == vb) return 3'b001;
    if (va < vb)  return 3'b010;
    return 3'b100;
  endfunction

  // Edges from accept to out_valid: set by the most significant differing chunk.
  function automatic int ref_lat(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb);
    int diff;
    diff = int'(ra ^ rb);
    for (int k = NCHUNK - 1; k >= 0; k--) begin
      if (((diff >> (k * CHUNK)) & ((1 << CHUNK) - 1)) != 0) return NCHUNK - k;
    end
    return NCHUNK;
  endfunction

  // Entered and left at 1 time unit after a rising edge, with the DUT idle.
  task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tsm,
                         input int hold);
    logic [2:0] exp_y;
    int exp_n;
    int n;
    exp_y = ref_rel(ta, tb, tsm);
    exp_n = ref_lat(ta, tb);
    check("in_ready_idle", in_ready, 1);
    a = ta;
    b = tb;
    signed_mode = tsm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    signed_mode = 1'($urandom);
    n = 0;
    while (!out_valid && n < NCHUNK + 2) begin
      check("run_busy", busy, 1);
      check("run_in_ready", in_ready, 0);
      check("run_y_held", y, prev_y);
      @(posedge clk); #1;
      n++;
    end
    check("done_reached", out_valid, 1);
    check("latency", n, exp_n);
    check("result", y, exp_y);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_y", y, exp_y);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_busy", busy, 0);
    check("release_y_kept", y, exp_y);
    prev_y = exp_y;
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    n_checks = 0;
    n_fail = 0;
    prev_y = 3'b000;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("reset_y", y, 3'b000);
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(8'h5A, 8'h5A, 1'b0, 0);
    run_txn(8'h40, 8'h80, 1'b0, 0);
    run_txn(8'h40, 8'h80, 1'b1, 1);
    run_txn(8'hFF, 8'h01, 1'b1, 0);
    run_txn(8'h03, 8'h02, 1'b0, 3);
    run_txn(8'h80, 8'h7F, 1'b1, 0);
    run_txn(8'h80, 8'h7F, 1'b0, 2);

    // Reset during RUN discards the compare.
    check("pre_reset_in_ready", in_ready, 1);
    a = 8'h5A;
    b = 8'h5A;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrun_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_valid", out_valid, 0);
    check("midrun_rst_y", y, 3'b000);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    prev_y = 3'b000;
    run_txn(8'h40, 8'h80, 1'b0, 0);

    for (int t = 0; t < 200; t++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        2: rb = ra ^ WIDTH'($urandom_range(1, (1 << CHUNK) - 1));
        default: rb = WIDTH'($urandom);
      endcase
      run_txn(ra, rb, 1'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
